sequential_divider: RTL and testbench

//   Multi-cycle unsigned restoring divider, one quotient bit per clock.

---
 rtl/sequential_divider_if.sv | 25 ++
 rtl/sequential_divider.sv | 110 +++++++++++
 tb/tb_sequential_divider.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sequential_divider_if.sv
// Start/done handshake bundle between a divider and the controller driving it.
// Operands flow toward the divider; status and results flow back.
interface sequential_divider_if #(
  parameter int N = 8,
  parameter int M = 4
);
  logic         start;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/sequential_divider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// Latency: done N+1 edges after an accepted start (1 edge for divide-by-zero).
// Backpressure: none; start is only honoured in IDLE and is never queued.
module sequential_divider #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  sequential_divider_if.slave       bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   dvd_q, dvd_d;
  logic [M-1:0]   dvs_q, dvs_d;
  logic [M-1:0]   p_q, p_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [M-1:0]   rem_q, rem_d;
  logic           dz_q, dz_d;

  logic [M:0]     p_shift;
  logic [M:0]     p_sub;
  logic           q_bit;
  logic [N-1:0]   dvd_next;

  // dvd_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  always_comb begin
    p_shift  = {p_q, dvd_q[N-1]};
    p_sub    = p_shift - {1'b0, dvs_q};
    q_bit    = (p_shift >= {1'b0, dvs_q});
    dvd_next = {dvd_q[N-2:0], q_bit};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d = bus.dividend;
          dvs_d = bus.divisor;
          p_d   = '0;
          rem_d = '0;
          if (bus.divisor == '0) begin
            quo_d   = '1;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            quo_d   = '0;
            dz_d    = 1'b0;
            cnt_d   = CW'(N);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dvd_d = dvd_next;
        p_d   = q_bit ? p_sub[M-1:0] : p_shift[M-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d   = dvd_next;
          rem_d   = q_bit ? p_sub[M-1:0] : p_shift[M-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy      = (state_q == CALC);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_sequential_divider.sv
// Directed and random division runs checked against plain integer / and %.
module tb_sequential_divider;
  localparam int N = 8;
  localparam int M = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  sequential_divider_if #(.N(N), .M(M)) bus ();

  sequential_divider #(.N(N), .M(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Entered just after a negedge with the DUT idle; returns just after a negedge, DUT idle.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                        input int inject_at);
    int lat;
    int busy_cnt;
    int exp_q;
    int exp_r;
    exp_q = (b == 0) ? 255 : int'(a) / int'(b);
    exp_r = (b == 0) ? 0   : int'(a) % int'(b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
    lat      = 1;
    busy_cnt = 0;
    if (b != 0) check({tag, " cleared"}, 32'(bus.quotient), 32'd0);
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_cnt++;
      if (lat == inject_at) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd10;
        bus.divisor  = 4'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 32'(lat), (b == 0) ? 32'd1 : 32'(N + 1));
    check({tag, " busy cycles"}, 32'(busy_cnt), (b == 0) ? 32'd0 : 32'(N));
    check({tag, " quotient"}, 32'(bus.quotient), 32'(exp_q));
    check({tag, " remainder"}, 32'(bus.remainder), 32'(exp_r));
    check({tag, " div_zero"}, 32'(bus.div_zero), (b == 0) ? 32'd1 : 32'd0);
    check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    check({tag, " done pulse width"}, 32'(bus.done), 32'd0);
    check({tag, " quotient held"}, 32'(bus.quotient), 32'(exp_q));
  endtask

  initial begin
    int dones;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset quotient", 32'(bus.quotient), 32'd0);
    check("reset remainder", 32'(bus.remainder), 32'd0);
    check("reset div_zero", 32'(bus.div_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("T1 45/5", 8'd45, 4'd5, -1);
    run_op("T2 200/7", 8'd200, 4'd7, -1);
    run_op("T3 7/15", 8'd7, 4'd15, -1);
    run_op("T3 255/1", 8'd255, 4'd1, -1);
    run_op("T4 0x80/0", 8'h80, 4'd0, -1);
    run_op("T5 22/2 with restart", 8'd22, 4'd2, 3);

    // Reset lands on the 4th CALC edge.
    bus.start    = 1'b1;
    bus.dividend = 8'd45;
    bus.divisor  = 4'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("T6 busy before reset", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("T6 busy after reset", 32'(bus.busy), 32'd0);
    check("T6 quotient after reset", 32'(bus.quotient), 32'd0);
    check("T6 remainder after reset", 32'(bus.remainder), 32'd0);
    check("T6 div_zero after reset", 32'(bus.div_zero), 32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    check("T6 no done after reset", 32'(dones), 32'd0);
    run_op("T6 10/2", 8'd10, 4'd2, -1);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] a;
      logic [3:0] b;
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      run_op($sformatf("rand%0d %0d/%0d", i, a, b), a, b, -1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
